coherence_bus_ctrl: RTL

Two-core snooping bus controller: the responder side of the dcache/icache-to-memory protocol. It arbitrates instruction fetches, dirty evictions and coherent read/read-exclusive requests from two cores. It broadcasts snoops to the non-requesting dcache and steers block data either cache-to-cache (with RAM writeback) or from RAM. It sits between the two cores' cache interfaces and the single-ported RAM.

---
 rtl/cpu_types_pkg.sv | 33 +++
 rtl/bus_arbiter.sv | 48 ++++
 rtl/coherence_bus_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the two-core snooping bus: RAM handshake states, bus
// controller states, grant kinds and the dcache block size.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IFETCH  = 3'd1,
    EVICT   = 3'd2,
    SNOOP   = 3'd3,
    C2C     = 3'd4,
    RAMRD   = 3'd5,
    UPGRADE = 3'd6
  } bus_state_t;

  typedef enum logic [1:0] {
    KIND_NONE   = 2'd0,
    KIND_IFETCH = 2'd1,
    KIND_EVICT  = 2'd2,
    KIND_COH    = 2'd3
  } req_kind_t;

  localparam int BLOCK_WORDS = 2;

endpackage

// File: rtl/bus_arbiter.sv
// Request arbiter for the coherence bus. Class priority is eviction
// (dWEN without cctrans) over coherent (cctrans) over instruction fetch.
// Ties between the two cores go to core 0, or to the core that did not win
// last time when BUS_ROUND_ROBIN_EN is defined.
module bus_arbiter
  import cpu_types_pkg::*;
(
  input  logic [1:0] iren,
  input  logic [1:0] dwen,
  input  logic [1:0] cctrans,
`ifdef BUS_ROUND_ROBIN_EN
  input  logic       last_grant,
`endif
  output logic       req,
  output req_kind_t  kind
);

  logic [1:0] evict_vec;
  logic [1:0] vec;
  logic       tie_winner;

  assign evict_vec = dwen & ~cctrans;

`ifdef BUS_ROUND_ROBIN_EN
  assign tie_winner = ~last_grant;
`else
  assign tie_winner = 1'b0;
`endif

  // pick the highest-priority request class, then the core within it
  always_comb begin
    kind = KIND_NONE;
    vec  = 2'b00;
    if (|evict_vec) begin
      kind = KIND_EVICT;
      vec  = evict_vec;
    end else if (|cctrans) begin
      kind = KIND_COH;
      vec  = cctrans;
    end else if (|iren) begin
      kind = KIND_IFETCH;
      vec  = iren;
    end
    if (vec == 2'b11) req = tie_winner;
    else              req = vec[1];
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Two-core snooping bus controller (responder side of the cache/memory
// protocol). Serves instruction fetches, dirty evictions and coherent
// reads / read-exclusives, snooping the other dcache and moving the block
// either cache-to-cache (with RAM writeback) or from RAM.
// Optional feature macro: BUS_ROUND_ROBIN_EN (round-robin tie breaking).
//
// state   | meaning
// IDLE    | no transaction, arbitrating
// IFETCH  | one instruction word read from RAM
// EVICT   | dirty block written to RAM word by word
// SNOOP   | snoop broadcast to the other dcache, waiting for its response
// C2C     | snooper supplies the Modified block, also written back to RAM
// RAMRD   | block read from RAM for the requester
// UPGRADE | ownership granted without data transfer
module coherence_bus_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CPUS        = 2,
  parameter int BLOCK_WORDS = cpu_types_pkg::BLOCK_WORDS
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [1:0]       iREN,
  input  logic [1:0][31:0] iaddr,
  output logic [1:0]       iwait,
  output logic [1:0][31:0] iload,
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  output logic [1:0]       dwait,
  output logic [1:0][31:0] dload,
  input  logic [1:0]       cctrans,
  input  logic [1:0]       ccwrite,
  output logic [1:0]       ccwait,
  output logic [1:0]       ccinv,
  output logic [1:0][31:0] ccsnoopaddr,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  ramstate_t        ramstate
);

  localparam int IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int CNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

  bus_state_t        state, next_state;
  logic [IDX_W-1:0]  req, next_req;
  logic [IDX_W-1:0]  other;
  logic [CNT_W-1:0]  word_cnt, next_cnt;
  logic              arb_req;
  req_kind_t         arb_kind;
  logic              access;
  logic              word_step;

  assign other  = ~req;
  assign access = (ramstate == ACCESS);

`ifdef BUS_ROUND_ROBIN_EN
  logic last_grant;

  // remember which core won the most recent grant out of IDLE
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                         last_grant <= 1'b0;
    else if (state == IDLE && arb_kind != KIND_NONE)   last_grant <= arb_req;
  end
`endif

  bus_arbiter u_arb (
    .iren       (iREN),
    .dwen       (dWEN),
    .cctrans    (cctrans),
`ifdef BUS_ROUND_ROBIN_EN
    .last_grant (last_grant),
`endif
    .req        (arb_req),
    .kind       (arb_kind)
  );

  // state, granted core and block word counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      req      <= '0;
      word_cnt <= '0;
    end else begin
      state    <= next_state;
      req      <= next_req;
      word_cnt <= next_cnt;
    end
  end

  // next state and bus outputs; data/wait releases gated by RAM ACCESS
  always_comb begin
    next_state  = state;
    next_req    = req;
    next_cnt    = word_cnt;
    word_step   = 1'b0;
    iwait       = 2'b11;
    dwait       = 2'b11;
    iload       = '0;
    dload       = '0;
    ccwait      = 2'b00;
    ccinv       = 2'b00;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    case (state)
      IDLE: begin
        if (arb_kind != KIND_NONE) begin
          next_req = IDX_W'(arb_req);
          case (arb_kind)
            KIND_IFETCH: next_state = IFETCH;
            KIND_EVICT:  next_state = EVICT;
            KIND_COH:    next_state = SNOOP;
            default:     next_state = IDLE;
          endcase
        end
      end
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[req];
        if (access) begin
          iload[req] = ramload;
          iwait[req] = 1'b0;
          next_state = IDLE;
        end
      end
      EVICT: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[req];
        ramstore = dstore[req];
        if (access) begin
          dwait[req] = 1'b0;
          word_step  = 1'b1;
        end
      end
      SNOOP: begin
        ccwait[other]      = 1'b1;
        ccsnoopaddr[other] = daddr[req];
        ccinv[other]       = ccwrite[req];
        if (cctrans[other]) begin
          if (ccwrite[other])  next_state = C2C;
          else if (dREN[req])  next_state = RAMRD;
          else                 next_state = UPGRADE;
        end
      end
      C2C: begin
        ccwait[other] = 1'b1;
        ramWEN        = 1'b1;
        ramaddr       = daddr[other];
        ramstore      = dstore[other];
        if (access) begin
          dload[req]   = dstore[other];
          dwait[req]   = 1'b0;
          dwait[other] = 1'b0;
          word_step    = 1'b1;
        end
      end
      RAMRD: begin
        ramREN  = 1'b1;
        ramaddr = daddr[req];
        if (access) begin
          dload[req] = ramload;
          dwait[req] = 1'b0;
          word_step  = 1'b1;
        end
      end
      UPGRADE: begin
        dwait[req] = 1'b0;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase

    // block transfers end by word count, wrapping the counter to 0
    if (word_step) begin
      if (word_cnt == LAST_WORD) begin
        next_cnt   = '0;
        next_state = IDLE;
      end else begin
        next_cnt = word_cnt + CNT_W'(1);
      end
    end
  end

endmodule
